alu_control_md: RTL and testbench
=================================

Name: alu_control_md

Overview:
- Sits between the ID/EX boundary and the ALU.
- Decodes ALUOp plus R-type funct into the registered 4-bit ALU control code: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
- Runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, into HI/LO registers.
- Raises a stall to hold the front end on HI/LO hazards.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CW, 4, ALU control code width.

Ports:
- clk  input  1  system clock; one clock domain.
- rst_n  input  1  reset is asynchronous and active-low.
- valid_in  input  1  instruction present at decode boundary.
- alu_op  input  2  00 ADD (lw/sw/addi), 01 SUB (beq), 10 R-type (use funct), 11 OR (ori).
- funct  input  6  R-type funct field.
- rs_data  input  WIDTH  operand A.
- rt_data  input  WIDTH  operand B.
- stall  output  1  combinational; upstream holds the instruction while high.
- control_input  output  CW  registered ALU control code.
- ctrl_valid  output  1  registered; control_input is valid this cycle.
- res_sel  output  2  registered result select: 00 ALU, 01 HI, 10 LO.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.
- md_busy  output  1  multiply/divide FSM not IDLE.
- md_done  output  1  one-cycle pulse when HI/LO are updated by mult/div.
- div_by_zero  output  1  sticky; cleared at the next mult/div start.

Behaviour:
- Accept condition: accept = valid_in & ~stall. Decode outputs register on accept, one cycle latency.
- Without accept: ctrl_valid=0; control_input and res_sel hold their values.
- Funct decode:
  - 0x20/0x21 -> 2; 0x22/0x23 -> 6; 0x24 -> 0; 0x25 -> 1; 0x27 -> 12; 0x2A -> 7.
  - 0x10 mfhi -> res_sel 01, code 2; 0x12 mflo -> res_sel 10, code 2.
  - 0x11 mthi / 0x13 mtlo: write HI/LO from rs_data at the accept edge.
  - 0x18/0x19/0x1A/0x1B: start the mult/div FSM; code 2; ctrl_valid=1.
  - Any other funct -> code 4'hF.
- Stall: stall = md_busy & valid_in & alu_op==10 & funct in {0x10..0x13, 0x18..0x1B}. Non-HI/LO instructions never stall.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on an accepted mult/multu; IDLE -> DIV on an accepted div/divu. Operands are latched at accept; signed ops latch absolute values plus sign flags.
  - MUL: shift-add for WIDTH cycles, 2*WIDTH-bit product.
  - DIV: restoring division for WIDTH cycles.
  - FIX: applies sign correction and writes HI/LO (mult: HI=upper, LO=lower; div: LO=quotient, HI=remainder). md_done pulses in this cycle; returns to IDLE.
- Total latency: start edge to HI/LO visible = WIDTH+1 cycles. md_busy is high during MUL/DIV/FIX.
- A hazard instruction presented during FIX stalls; it is accepted in the first IDLE cycle and sees the new HI/LO.
- Divide by zero: skip DIV (IDLE -> FIX next cycle); LO=all ones, HI=dividend, div_by_zero=1.
- Signed -2^(WIDTH-1) / -1: LO=0x80000000, HI=0, no flag.
- Remainder sign follows the dividend.
- Reset, including mid-operation: FSM -> IDLE; HI, LO, control_input = 0; res_sel = 00; ctrl_valid, md_busy, md_done, div_by_zero = 0. Any in-flight op is discarded.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_EN.
- Defined: adds output illegal_op (1 bit, registered, reset 0). It pulses with ctrl_valid when an accepted alu_op=10 instruction has an undecoded funct. Code 4'hF is still driven.
- Undefined: port absent; undecoded funct silently produces 4'hF.

Decomposition:
- Package alu_pkg holds:
  - ALU code constants (AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, BAD=15).
  - alu_op enum; funct localparams.
  - res_sel enum; md FSM state enum.
- Sub-module md_iter: iterative mul/div datapath, sign handling and FIX logic.
- The top module keeps the decode, stall and output registers.

Test Plan:
- alu_op=10, funct=0x2A, valid_in=1 -> next cycle control_input=7, ctrl_valid=1, res_sel=00. Repeat for 0x24/0x25/0x27/0x22 -> 0/1/12/6.
- mult rs=0xFFFFFFFE (-2), rt=3 -> md_done after 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5, div_by_zero=1.
- mflo presented 1 cycle after a mult start -> stall high until FIX completes; accepted in the first IDLE cycle; res_sel=10 and LO is already updated. An add presented mid-busy -> no stall.
- rst_n pulled low at cycle 10 of a divide -> md_busy=0 and HI=LO=0 immediately; a new multu 2*3 then gives LO=6.
- With ALU_CTRL_ILLEGAL_EN: funct=0x3F -> illegal_op=1 and control_input=0xF for one cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU control / multiply-divide slice.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_BAD = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_OR    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_HI  = 2'b01,
    RES_LO  = 2'b10
  } res_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX
  } md_state_e;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;

  function automatic logic is_md_funct(input logic [5:0] f);
    return (f >= F_MULT) && (f <= F_DIVU);
  endfunction

  function automatic logic is_hilo_funct(input logic [5:0] f);
    return ((f >= F_MFHI) && (f <= F_MTLO)) || is_md_funct(f);
  endfunction

  function automatic logic is_known_funct(input logic [5:0] f);
    return is_hilo_funct(f) || (f == F_ADD) || (f == F_ADDU) || (f == F_SUB) ||
           (f == F_SUBU) || (f == F_AND) || (f == F_OR) || (f == F_NOR) || (f == F_SLT);
  endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative one-bit-per-cycle multiply/divide datapath owning the HI/LO registers.
module md_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned CNTW = $clog2(WIDTH);

  md_state_e          r_state, w_next;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb, r_hi, r_lo;
  logic [CNTW-1:0]    r_cnt;
  logic               r_is_div, r_zero_op, r_neg_lo, r_neg_hi, r_dbz;

  logic               w_signed, w_a_neg, w_b_neg, w_b_zero, w_last;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH:0]     w_sum, w_shift, w_trial;
  logic [2*WIDTH-1:0] w_div_nxt, w_prod_fix;

  // op[1] selects divide, op[0] selects the unsigned variant
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_abs  = w_b_neg ? (~b + 1'b1) : b;
  assign w_b_zero = (b == '0);
  assign w_last   = (r_cnt == CNTW'(WIDTH - 1));

  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  // Restoring step: upper half is the partial remainder, lower half shifts quotient bits in
  assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial = w_shift - {1'b0, r_opb};
  assign w_div_nxt = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_prod_fix = r_neg_lo ? (~r_acc + 1'b1) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (start) w_next = op[1] ? (w_b_zero ? MD_FIX : MD_DIV) : MD_MUL;
      MD_MUL:  if (w_last) w_next = MD_FIX;
      MD_DIV:  if (w_last) w_next = MD_FIX;
      default: w_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != MD_IDLE);
    done = (r_state == MD_FIX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_opb     <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_zero_op <= 1'b0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      if (wr_hi) r_hi <= wr_data;
      if (wr_lo) r_lo <= wr_data;
      case (r_state)
        MD_IDLE: if (start) begin
          r_cnt     <= '0;
          r_is_div  <= op[1];
          r_zero_op <= op[1] & w_b_zero;
          r_dbz     <= 1'b0;
          r_opb     <= w_b_abs;
          r_neg_lo  <= w_a_neg ^ w_b_neg;
          r_neg_hi  <= op[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
          r_acc     <= (op[1] & w_b_zero) ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_a_abs};
        end
        MD_MUL: begin
          r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        MD_DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          if (r_zero_op) begin
            r_hi  <= r_acc[2*WIDTH-1:WIDTH];
            r_lo  <= r_acc[WIDTH-1:0];
            r_dbz <= 1'b1;
          end else if (r_is_div) begin
            r_lo <= r_neg_lo ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
            r_hi <= r_neg_hi ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
      endcase
    end
  end

  assign hi  = r_hi;
  assign lo  = r_lo;
  assign dbz = r_dbz;

endmodule

// File: rtl/alu_control_md.sv
// ALU control decode with HI/LO hazard stall and iterative mult/div.
// Optional ALU_CTRL_ILLEGAL_EN adds the registered illegal_op flag.
module alu_control_md
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic [CW-1:0]    control_input,
  output logic             ctrl_valid,
  output logic [1:0]       res_sel,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             md_busy,
  output logic             md_done,
  output logic             div_by_zero
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic             illegal_op
`endif
);

  logic          w_rtype, w_accept, w_start, w_wr_hi, w_wr_lo, w_busy;
  logic [3:0]    w_code;
  res_sel_e      w_sel;
  logic [CW-1:0] r_ctrl;
  logic          r_valid;
  res_sel_e      r_res_sel;

  assign w_rtype  = (alu_op_e'(alu_op) == OP_RTYPE);
  assign stall    = w_busy & valid_in & w_rtype & is_hilo_funct(funct);
  assign w_accept = valid_in & ~stall;
  assign w_start  = w_accept & w_rtype & is_md_funct(funct);
  assign w_wr_hi  = w_accept & w_rtype & (funct == F_MTHI);
  assign w_wr_lo  = w_accept & w_rtype & (funct == F_MTLO);

  always_comb begin
    w_code = ALU_ADD;
    w_sel  = RES_ALU;
    case (alu_op_e'(alu_op))
      OP_ADD: w_code = ALU_ADD;
      OP_SUB: w_code = ALU_SUB;
      OP_OR:  w_code = ALU_OR;
      default: begin
        case (funct)
          F_ADD, F_ADDU: w_code = ALU_ADD;
          F_SUB, F_SUBU: w_code = ALU_SUB;
          F_AND:         w_code = ALU_AND;
          F_OR:          w_code = ALU_OR;
          F_NOR:         w_code = ALU_NOR;
          F_SLT:         w_code = ALU_SLT;
          F_MFHI:        w_sel  = RES_HI;
          F_MFLO:        w_sel  = RES_LO;
          F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: w_code = ALU_ADD;
          default:       w_code = ALU_BAD;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_res_sel <= RES_ALU;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_ctrl    <= CW'(w_code);
        r_res_sel <= w_sel;
      end
    end
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else        r_illegal <= w_accept & w_rtype & ~is_known_funct(funct);
  end
  assign illegal_op = r_illegal;
`endif

  md_iter #(.WIDTH(WIDTH)) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_start),
    .op      (funct[1:0]),
    .a       (rs_data),
    .b       (rt_data),
    .wr_hi   (w_wr_hi),
    .wr_lo   (w_wr_lo),
    .wr_data (rs_data),
    .hi      (hi_out),
    .lo      (lo_out),
    .busy    (w_busy),
    .done    (md_done),
    .dbz     (div_by_zero)
  );

  assign md_busy       = w_busy;
  assign control_input = r_ctrl;
  assign ctrl_valid    = r_valid;
  assign res_sel       = r_res_sel;

endmodule

// File: tb/tb_alu_control_md.sv
// Self-checking bench for alu_control_md: decode table, directed mult/div corners, random mult/div.
module tb_alu_control_md;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic [W-1:0]  rs_data, rt_data;
  logic          stall, ctrl_valid, md_busy, md_done, div_by_zero;
  logic [3:0]    control_input;
  logic [1:0]    res_sel;
  logic [W-1:0]  hi_out, lo_out;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic          illegal_op;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_control_md #(.WIDTH(W), .CW(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .alu_op        (alu_op),
    .funct         (funct),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .stall         (stall),
    .control_input (control_input),
    .ctrl_valid    (ctrl_valid),
    .res_sel       (res_sel),
    .hi_out        (hi_out),
    .lo_out        (lo_out),
    .md_busy       (md_busy),
    .md_done       (md_done),
    .div_by_zero   (div_by_zero)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] code;
    logic [1:0] sel;
    logic       bad;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_in = 1'b0;
    alu_op   = 2'b00;
    funct    = 6'h00;
    rs_data  = '0;
    rt_data  = '0;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operand values
  task automatic md_model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'h18: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      6'h19: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else if (f == 6'h1A) begin
          q = sa / sb; r = sa % sb;
          p = 64'(q); lo = p[31:0];
          p = 64'(r); hi = p[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endtask

  task automatic run_md(input string nm, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [W-1:0] ehi, elo;
    logic edz;
    int n;
    md_model(f, a, b, ehi, elo, edz);
    valid_in = 1'b1; alu_op = 2'b10; funct = f; rs_data = a; rt_data = b;
    step();
    idle_in();
    chk({nm, ".busy"}, 64'(md_busy), 64'd1);
    chk({nm, ".dbz_clr"}, 64'(div_by_zero), 64'd0);
    chk({nm, ".ctrl"}, {59'd0, ctrl_valid, control_input}, {59'd0, 1'b1, 4'd2});
    n = 0;
    while (!md_done && n < 200) begin
      step();
      n++;
    end
    chk({nm, ".latency"}, 64'(n), (f[1] && b == 0) ? 64'd0 : 64'(W));
    step();
    chk({nm, ".hi"}, 64'(hi_out), 64'(ehi));
    chk({nm, ".lo"}, 64'(lo_out), 64'(elo));
    chk({nm, ".dbz"}, 64'(div_by_zero), 64'(edz));
    chk({nm, ".idle"}, 64'(md_busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ehi, elo, a, b;
    logic edz;
    logic [5:0] f;
    int n;

    rst_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ctrl", {58'd0, ctrl_valid, control_input, res_sel[0]},  64'd0);
    chk("rst.sel",  64'(res_sel), 64'd0);
    chk("rst.hilo", {hi_out, lo_out}, 64'd0);
    chk("rst.md",   {61'd0, md_busy, md_done, div_by_zero}, 64'd0);
    rst_n = 1'b1;
    step();

    tbl.push_back('{2'b10, 6'h2A, 4'd7,  2'b00, 1'b0});
    tbl.push_back('{2'b10, 6'h24, 4'd0,  2'b00, 1'b0});
    tbl.push_back('{2'b10, 6'h25, 4'd1,  2'b00, 1'b0});
    tbl.push_back('{2'b10, 6'h27, 4'd12, 2'b00, 1'b0});
    tbl.push_back('{2'b10, 6'h22, 4'd6,  2'b00, 1'b0});
    tbl.push_back('{2'b10, 6'h23, 4'd6,  2'b00, 1'b0});
    tbl.push_back('{2'b10, 6'h20, 4'd2,  2'b00, 1'b0});
    tbl.push_back('{2'b10, 6'h21, 4'd2,  2'b00, 1'b0});
    tbl.push_back('{2'b10, 6'h10, 4'd2,  2'b01, 1'b0});
    tbl.push_back('{2'b10, 6'h12, 4'd2,  2'b10, 1'b0});
    tbl.push_back('{2'b00, 6'h3F, 4'd2,  2'b00, 1'b0});
    tbl.push_back('{2'b01, 6'h00, 4'd6,  2'b00, 1'b0});
    tbl.push_back('{2'b11, 6'h15, 4'd1,  2'b00, 1'b0});
    tbl.push_back('{2'b10, 6'h3F, 4'd15, 2'b00, 1'b1});
    tbl.push_back('{2'b10, 6'h00, 4'd15, 2'b00, 1'b1});

    foreach (tbl[i]) begin
      valid_in = 1'b1; alu_op = tbl[i].op; funct = tbl[i].f;
      step();
      chk($sformatf("dec[%0d].code", i), 64'(control_input), 64'(tbl[i].code));
      chk($sformatf("dec[%0d].valid", i), 64'(ctrl_valid), 64'd1);
      chk($sformatf("dec[%0d].sel", i), 64'(res_sel), 64'(tbl[i].sel));
`ifdef ALU_CTRL_ILLEGAL_EN
      chk($sformatf("dec[%0d].illegal", i), 64'(illegal_op), 64'(tbl[i].bad));
`endif
    end
    idle_in();
    step();
    chk("noacc.valid", 64'(ctrl_valid), 64'd0);
    chk("noacc.hold", 64'(control_input), 64'd15);
`ifdef ALU_CTRL_ILLEGAL_EN
    chk("noacc.illegal", 64'(illegal_op), 64'd0);
`endif

    // mthi / mtlo write at the accept edge
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'h11; rs_data = 32'h1234_5678;
    step();
    funct = 6'h13; rs_data = 32'h9ABC_DEF0;
    step();
    idle_in();
    chk("mthi", 64'(hi_out), 64'h1234_5678);
    chk("mtlo", 64'(lo_out), 64'h9ABC_DEF0);

    run_md("mult_m2x3",  6'h18, 32'hFFFF_FFFE, 32'd3);
    chk("mult_m2x3.const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_md("multu_m2x3", 6'h19, 32'hFFFF_FFFE, 32'd3);
    chk("multu_m2x3.const", {hi_out, lo_out}, 64'h0000_0002_FFFF_FFFA);
    run_md("div_m7x2",   6'h1A, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7x2.const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md("div_5x0",    6'h1A, 32'd5, 32'd0);
    chk("div_5x0.const", {31'd0, div_by_zero, hi_out, lo_out}, {31'd0, 1'b1, 32'd5, 32'hFFFF_FFFF});
    run_md("div_min",    6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min.const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
    run_md("divu_big",   6'h1B, 32'hFFFF_FFFF, 32'd10);

    // mflo behind a running mult: stalls through FIX, accepted first IDLE cycle
    md_model(6'h18, 32'hFFFF_FFF0, 32'd7, ehi, elo, edz);
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'h18; rs_data = 32'hFFFF_FFF0; rt_data = 32'd7;
    step();
    funct = 6'h12; rs_data = '0; rt_data = '0;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      step();
    end
    chk("haz.stall_cycles", 64'(n), 64'(W + 1));
    chk("haz.idle", 64'(md_busy), 64'd0);
    chk("haz.lo_new", 64'(lo_out), 64'(elo));
    step();
    idle_in();
    chk("haz.accept", {59'd0, ctrl_valid, control_input}, {59'd0, 1'b1, 4'd2});
    chk("haz.sel", 64'(res_sel), 64'd2);

    // non-HI/LO instruction during busy never stalls
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'h1B; rs_data = 32'd100; rt_data = 32'd7;
    step();
    alu_op = 2'b00; funct = 6'h00;
    #1;
    chk("nohaz.stall", 64'(stall), 64'd0);
    step();
    idle_in();
    chk("nohaz.accept", {59'd0, ctrl_valid, control_input}, {59'd0, 1'b1, 4'd2});
    n = 0;
    while (!md_done && n < 100) begin
      step();
      n++;
    end
    step();
    chk("nohaz.divu", {hi_out, lo_out}, {32'd2, 32'd14});

    // reset mid-divide
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'h1A; rs_data = 32'd1000; rt_data = 32'd3;
    step();
    idle_in();
    repeat (9) step();
    chk("rstmid.busy_before", 64'(md_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.busy", 64'(md_busy), 64'd0);
    chk("rstmid.hilo", {hi_out, lo_out}, 64'd0);
    chk("rstmid.ctrl", {58'd0, ctrl_valid, control_input, md_done}, 64'd0);
    #3 rst_n = 1'b1;
    step();
    run_md("multu_2x3", 6'h19, 32'd2, 32'd3);
    chk("multu_2x3.const", 64'(lo_out), 64'd6);

    for (int i = 0; i < 12; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255));
      run_md($sformatf("rnd[%0d]", i), f, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
